// File: rtl/obstacle_field_if.sv
// Scan position, player position and obstacle colour/status bundle between the VGA
// sync counters, the colour mux and obstacle_field.
interface obstacle_field_if #(
    parameter int unsigned LANES = 4
);
    logic             start;
    logic             pause;
    logic [9:0]       CounterX;
    logic [8:0]       CounterY;
    logic [9:0]       player_x;
    logic             obj_R;
    logic             obj_G;
    logic             obj_B;
    logic             check;
    logic             Oncollision;
    logic [15:0]      score;
    logic [LANES-1:0] lane_active;
    logic [2:0]       speed;
    logic [1:0]       state;

    modport master (
        output start, pause, CounterX, CounterY, player_x,
        input  obj_R, obj_G, obj_B, check, Oncollision, score, lane_active, speed, state
    );

    modport slave (
        input  start, pause, CounterX, CounterY, player_x,
        output obj_R, obj_G, obj_B, check, Oncollision, score, lane_active, speed, state
    );
endinterface

// File: rtl/obstacle_field.sv
// Multi-lane obstacle generator: per-lane scroll, LFSR spawning, collision against the
// player car and registered obstacle pixel colour for the current scan position.
module obstacle_field #(
    parameter int unsigned LANES       = 4,
    parameter int unsigned LANE_X0     = 93,
    parameter int unsigned LANE_PITCH  = 125,
    parameter int unsigned SPRITE_W    = 89,
    parameter int unsigned SPRITE_H    = 69,
    parameter int unsigned SCREEN_H    = 480,
    parameter int unsigned PLAYER_Y0   = 345,
    parameter int unsigned PLAYER_Y1   = 445,
    parameter int unsigned PLAYER_W    = 89,
    parameter int unsigned STEP_DIV    = 65536,
    parameter int unsigned SPAWN_GAP   = 96,
    parameter int unsigned LEVEL_SCORE = 8,
    parameter int unsigned MAX_SPEED   = 6
) (
    input logic             clk,
    input logic             rst_n,
    obstacle_field_if.slave bus
);
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] HIT  = 2'b10;

    localparam int unsigned DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned GAP_W = $clog2(SPAWN_GAP + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SPAWN_GAP - 1);

    // Signed copies so position arithmetic with negative y compares correctly.
    localparam int NL    = int'(LANES);
    localparam int X0    = int'(LANE_X0);
    localparam int PITCH = int'(LANE_PITCH);
    localparam int SPR_W = int'(SPRITE_W);
    localparam int SPR_H = int'(SPRITE_H);
    localparam int SCR_H = int'(SCREEN_H);
    localparam int PY0   = int'(PLAYER_Y0);
    localparam int PY1   = int'(PLAYER_Y1);
    localparam int PL_W  = int'(PLAYER_W);

    logic [1:0]         state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [GAP_W-1:0]   spawn_q, spawn_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic signed [10:0] y_q [LANES];
    logic signed [10:0] y_d [LANES];
    logic [LANES-1:0]   act_q, act_d;
    logic [15:0]        score_q, score_d;
    logic [2:0]         speed_q, speed_d;
    logic               hit_q, hit_d;
    logic               check_q, yellow_q;
    logic               step, collide, pix;
    int                 exits, ny, k;
    logic [16:0]        sum;

    function automatic int lane_left(int i);
        return X0 + i * PITCH;
    endfunction

    function automatic logic in_range(int v, int lo, int hi);
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic logic [2:0] speed_for(logic [15:0] s);
        int unsigned lvl;
        lvl = 32'(s) / LEVEL_SCORE;
        if (lvl + 1 >= MAX_SPEED) return 3'(MAX_SPEED);
        return 3'(lvl + 1);
    endfunction

    assign step = (state_q == RUN) && (div_q == DIV_LAST) && !bus.pause;

    always_comb begin
        collide = 1'b0;
        pix     = 1'b0;
        for (int i = 0; i < NL; i++) begin
            if (act_q[i]) begin
                if (in_range(lane_left(i), int'(bus.player_x) - SPR_W + 1,
                             int'(bus.player_x) + PL_W - 1) &&
                    in_range(int'(y_q[i]), PY0 - SPR_H + 1, PY1)) begin
                    collide = 1'b1;
                end
                if (in_range(int'(bus.CounterX), lane_left(i), lane_left(i) + SPR_W - 1) &&
                    in_range(int'(bus.CounterY), int'(y_q[i]), int'(y_q[i]) + SPR_H - 1)) begin
                    pix = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        spawn_d = spawn_q;
        lfsr_d  = lfsr_q;
        y_d     = y_q;
        act_d   = act_q;
        score_d = score_q;
        speed_d = speed_q;
        hit_d   = hit_q;
        exits   = 0;
        ny      = 0;
        k       = 0;
        sum     = '0;
        if (state_q != RUN) begin
            if (bus.start) begin
                state_d = RUN;
                hit_d   = 1'b0;
                act_d   = '0;
                for (int i = 0; i < NL; i++) y_d[i] = '0;
                score_d = '0;
                speed_d = 3'd1;
                div_d   = '0;
                spawn_d = '0;
            end
        end else if (collide) begin
            // Collision wins over any motion, exit or spawn due on this edge.
            state_d = HIT;
            hit_d   = 1'b1;
        end else if (!bus.pause) begin
            div_d = step ? '0 : div_q + 1'b1;
            if (step) begin
                speed_d = speed_for(score_q);
                for (int i = 0; i < NL; i++) begin
                    if (act_q[i]) begin
                        ny     = int'(y_q[i]) + int'(speed_q);
                        y_d[i] = 11'(ny);
                        if (ny >= SCR_H) begin
                            act_d[i] = 1'b0;
                            exits    = exits + 1;
                        end
                    end
                end
                sum     = {1'b0, score_q} + 17'(exits);
                score_d = sum[16] ? 16'hFFFF : sum[15:0];
                if (spawn_q == GAP_LAST) begin
                    spawn_d = '0;
                    k       = int'(32'(lfsr_q) % LANES);
                    for (int j = 0; j < NL; j++) begin
                        if (j == k && !act_d[j]) begin
                            act_d[j] = 1'b1;
                            y_d[j]   = 11'(-SPR_H);
                        end
                    end
                end else begin
                    spawn_d = spawn_q + 1'b1;
                end
                lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            div_q    <= '0;
            spawn_q  <= '0;
            lfsr_q   <= 16'hACE1;
            for (int i = 0; i < NL; i++) y_q[i] <= '0;
            act_q    <= '0;
            score_q  <= '0;
            speed_q  <= 3'd1;
            hit_q    <= 1'b0;
            check_q  <= 1'b0;
            yellow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            spawn_q  <= spawn_d;
            lfsr_q   <= lfsr_d;
            for (int i = 0; i < NL; i++) y_q[i] <= y_d[i];
            act_q    <= act_d;
            score_q  <= score_d;
            speed_q  <= speed_d;
            hit_q    <= hit_d;
            check_q  <= pix;
            yellow_q <= pix && (state_q == HIT);
        end
    end

    assign bus.check       = check_q;
    assign bus.obj_R       = check_q;
    assign bus.obj_G       = yellow_q;
    assign bus.obj_B       = 1'b0;
    assign bus.Oncollision = hit_q;
    assign bus.score       = score_q;
    assign bus.lane_active = act_q;
    assign bus.speed       = speed_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_obstacle_field.sv
// Directed bench for obstacle_field with STEP_DIV=4 and SPAWN_GAP=2.
module tb_obstacle_field;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    obstacle_field_if #(.LANES(4)) bus ();

    obstacle_field #(
        .LANES    (4),
        .STEP_DIV (4),
        .SPAWN_GAP(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [9:0] cx;
        logic [8:0] cy;
        logic       r;
        logic       g;
    } pix_t;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    task automatic apply_pix(input pix_t v, input string tag);
        @(negedge clk);
        bus.CounterX = v.cx;
        bus.CounterY = v.cy;
        @(posedge clk);
        #1;
        chk({tag, " check"}, 32'(bus.check), 32'(v.r));
        chk({tag, " R"}, 32'(bus.obj_R), 32'(v.r));
        chk({tag, " G"}, 32'(bus.obj_G), 32'(v.g));
        chk({tag, " B"}, 32'(bus.obj_B), 32'd0);
    endtask

    function automatic int exp_speed(input int s);
        int v;
        v = 1 + s / 8;
        return (v > 6) ? 6 : v;
    endfunction

    pix_t run_tab[13];
    pix_t hit_tab[6];
    int   prev_score;
    bit   done;

    initial begin
        // Lanes at step 177: lane0 y=106, lane1 y=100, lane3 y=102.
        run_tab[0]  = '{10'd218, 9'd100, 1'b1, 1'b0};
        run_tab[1]  = '{10'd217, 9'd100, 1'b0, 1'b0};
        run_tab[2]  = '{10'd218, 9'd169, 1'b0, 1'b0};
        run_tab[3]  = '{10'd306, 9'd168, 1'b1, 1'b0};
        run_tab[4]  = '{10'd307, 9'd120, 1'b0, 1'b0};
        run_tab[5]  = '{10'd250, 9'd99,  1'b0, 1'b0};
        run_tab[6]  = '{10'd93,  9'd106, 1'b1, 1'b0};
        run_tab[7]  = '{10'd92,  9'd106, 1'b0, 1'b0};
        run_tab[8]  = '{10'd181, 9'd174, 1'b1, 1'b0};
        run_tab[9]  = '{10'd100, 9'd175, 1'b0, 1'b0};
        run_tab[10] = '{10'd468, 9'd102, 1'b1, 1'b0};
        run_tab[11] = '{10'd556, 9'd170, 1'b1, 1'b0};
        run_tab[12] = '{10'd557, 9'd150, 1'b0, 1'b0};
        // Frozen at hit: lane0 y=277, spans y 277..345.
        hit_tab[0]  = '{10'd100, 9'd277, 1'b1, 1'b1};
        hit_tab[1]  = '{10'd100, 9'd276, 1'b0, 1'b0};
        hit_tab[2]  = '{10'd100, 9'd345, 1'b1, 1'b1};
        hit_tab[3]  = '{10'd100, 9'd346, 1'b0, 1'b0};
        hit_tab[4]  = '{10'd181, 9'd300, 1'b1, 1'b1};
        hit_tab[5]  = '{10'd182, 9'd300, 1'b0, 1'b0};

        bus.start    = 1'b0;
        bus.pause    = 1'b0;
        bus.CounterX = '0;
        bus.CounterY = '0;
        bus.player_x = 10'd600;

        #12;
        chk("reset state", 32'(bus.state), 32'd0);
        chk("reset score", 32'(bus.score), 32'd0);
        chk("reset speed", 32'(bus.speed), 32'd1);
        chk("reset lanes", 32'(bus.lane_active), 32'd0);
        chk("reset collision", 32'(bus.Oncollision), 32'd0);
        chk("reset check", 32'(bus.check), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("run after start", 32'(bus.state), 32'd1);

        for (int s = 1; s <= 177; s++) begin
            repeat (4) @(posedge clk);
            #1;
            if (s == 1) chk("lanes step1", 32'(bus.lane_active), 32'h0);
            if (s == 2) chk("lanes step2", 32'(bus.lane_active), 32'h1);
            if (s == 4) chk("lanes step4 skip", 32'(bus.lane_active), 32'h1);
            if (s == 6) chk("lanes step6", 32'(bus.lane_active), 32'h9);
            if (s == 8) chk("lanes step8", 32'(bus.lane_active), 32'hB);
        end

        bus.pause = 1'b1;
        repeat (1000) @(posedge clk);
        #1;
        chk("paused score", 32'(bus.score), 32'd0);
        chk("paused lanes", 32'(bus.lane_active & 4'hB), 32'hB);
        chk("paused speed", 32'(bus.speed), 32'd1);
        for (int i = 0; i < 13; i++) apply_pix(run_tab[i], $sformatf("run pix %0d", i));

        @(negedge clk);
        bus.CounterX = 10'd93;
        bus.CounterY = 9'd106;
        bus.player_x = 10'd100;
        bus.pause    = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("resume before step", 32'(bus.check), 32'd1);
        @(posedge clk);
        #1;
        chk("resume after step", 32'(bus.check), 32'd0);

        repeat (679) @(posedge clk);
        #1;
        chk("overlap edge state", 32'(bus.state), 32'd1);
        chk("overlap edge flag", 32'(bus.Oncollision), 32'd0);
        @(posedge clk);
        #1;
        chk("hit state", 32'(bus.state), 32'd2);
        chk("hit flag", 32'(bus.Oncollision), 32'd1);
        chk("hit score", 32'(bus.score), 32'd0);

        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 6; i++) apply_pix(hit_tab[i], $sformatf("hit pix %0d.%0d", p, i));
            repeat (40) @(posedge clk);
        end

        @(negedge clk);
        bus.player_x = 10'd600;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("restart state", 32'(bus.state), 32'd1);
        chk("restart flag", 32'(bus.Oncollision), 32'd0);
        chk("restart score", 32'(bus.score), 32'd0);
        chk("restart lanes", 32'(bus.lane_active), 32'd0);
        chk("restart speed", 32'(bus.speed), 32'd1);

        prev_score = 0;
        done       = 1'b0;
        for (int s = 1; s <= 8000 && !done; s++) begin
            repeat (4) @(posedge clk);
            #1;
            if (s == 1) chk("rerun lanes step1", 32'(bus.lane_active), 32'd0);
            if (s == 2) chk("rerun one spawn", 32'($countones(bus.lane_active)), 32'd1);
            if (s == 550) chk("score before exit", 32'(bus.score), 32'd0);
            if (s == 551) chk("score after exit", 32'(bus.score), 32'd1);
            chk($sformatf("speed rule step %0d", s), 32'(bus.speed), 32'(exp_speed(prev_score)));
            prev_score = int'(bus.score);
            if (prev_score >= 48) done = 1'b1;
        end
        chk("score reached 48", 32'(done), 32'd1);
        chk("speed capped", 32'(bus.speed), 32'd6);

        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun reset state", 32'(bus.state), 32'd0);
        chk("midrun reset score", 32'(bus.score), 32'd0);
        chk("midrun reset speed", 32'(bus.speed), 32'd1);
        chk("midrun reset lanes", 32'(bus.lane_active), 32'd0);
        chk("midrun reset check", 32'(bus.obj_R), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
